usart_clk_ctrl: RTL and testbench

//  Sequencer and configuration owner for USART_GENClock. Takes CPU config writes
//  (Mode/Sync/Baudrate) and applies them only at a safe point: waits for TX/RX idle,

---
 rtl/usart_pkg.sv | 31 +++
 rtl/usart_edge_sync.sv | 26 ++
 rtl/usart_clk_ctrl.sv | 168 ++++++++++++++++
 tb/tb_usart_clk_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// Shared definitions for the USART clock controller: FSM encoding,
// CfgData field positions and the applied-configuration record.
package usart_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_HOLD      = 2'd2,
    ST_LOCK      = 2'd3
  } ctrlState_e;

  localparam int CFG_MODE_BIT = 5;
  localparam int CFG_SYNC_BIT = 4;
  localparam int CFG_BAUD_MSB = 3;
  localparam int CFG_BAUD_LSB = 0;

  localparam logic [3:0] MAX_BAUD = 4'd13;

  // Bit layout deliberately matches CfgData so a write can be cast directly.
  typedef struct packed {
    logic       mode;
    logic       sync;
    logic [3:0] baud;
  } genCfg_t;

  // Baudrate codes 14 and 15 have no generator setting and are rejected.
  function automatic logic cfgIsValid(input logic [5:0] data);
    return data[CFG_BAUD_MSB:CFG_BAUD_LSB] <= MAX_BAUD;
  endfunction

endpackage

// File: rtl/usart_edge_sync.sv
// Brings the asynchronous generator clock into the CPUClk domain and
// produces a one-cycle pulse for each rising edge.
module usart_edge_sync
  import usart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  // [0] and [1] form the two-flop synchronizer, [2] holds the previous synced level.
  logic [2:0] sync_q;

  // Shift the raw level through the synchronizer and edge register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/usart_clk_ctrl.sv
// Configuration owner and tick sequencer for USART_GENClock: defers config
// writes to a safe point, resets the generator, waits for lock and turns
// generator edges into TxTick/RxTick enables.
module usart_clk_ctrl
  import usart_pkg::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int TMO_W        = 16
) (
  input  logic       CPUClk,
  input  logic       Reset_n,
  input  logic       CfgWr,
  input  logic [5:0] CfgData,
  input  logic       TxBusy,
  input  logic       RxBusy,
  input  logic       InClk,
  output logic       GenReset,
  output logic       GenMode,
  output logic       GenSync,
  output logic [3:0] GenBaudrate,
  output logic       TxTick,
  output logic       RxTick,
  output logic       CfgBusy,
  output logic       CfgErr,
  output logic       LockErr
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DIV_W  = $clog2(OVERSAMPLE);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(OVERSAMPLE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT);

  ctrlState_e        state_q, state_d;
  logic [HOLD_W-1:0] holdCnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [DIV_W-1:0]  divCnt_q;
  genCfg_t           shadow_q;
  genCfg_t           gen_q;
  logic              genReset_q;
  logic              cfgErr_q;
  logic              lockErr_q;

  logic inRise;
  logic wrValid;
  logic busIdle;
  logic holdDone;
  logic tmoDone;
  logic inRun;

  usart_edge_sync u_edge_sync (
    .clk_i   (CPUClk),
    .rst_ni  (Reset_n),
    .async_i (InClk),
    .rise_o  (inRise)
  );

  assign wrValid  = cfgIsValid(CfgData);
  assign busIdle  = !TxBusy && !RxBusy;
  assign holdDone = (holdCnt_q == HOLD_LAST);
  assign tmoDone  = (tmo_q == TMO_LAST);
  assign inRun    = (state_q == ST_RUN);

  // State register; reset lands in HOLD so the generator comes up through a full bring-up.
  always_ff @(posedge CPUClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the reconfiguration sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:       if (CfgWr && wrValid) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (busIdle) state_d = ST_HOLD;
      ST_HOLD:      if (holdDone) state_d = ST_LOCK;
      ST_LOCK:      if (inRise || tmoDone) state_d = ST_RUN;
      default:      state_d = ST_HOLD;
    endcase
  end

  // Config shadow, applied settings, counters and sticky error flags.
  always_ff @(posedge CPUClk or negedge Reset_n) begin
    if (!Reset_n) begin
      holdCnt_q  <= '0;
      tmo_q      <= '0;
      divCnt_q   <= '0;
      shadow_q   <= '0;
      gen_q      <= '0;
      genReset_q <= 1'b1;
      cfgErr_q   <= 1'b0;
      lockErr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (CfgWr) begin
            if (wrValid) begin
              shadow_q  <= genCfg_t'(CfgData);
              cfgErr_q  <= 1'b0;
              lockErr_q <= 1'b0;
            end else begin
              cfgErr_q <= 1'b1;
            end
          end
          if (inRise && !gen_q.sync) begin
            divCnt_q <= (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (CfgWr) begin
            if (wrValid) begin
              shadow_q  <= genCfg_t'(CfgData);
              cfgErr_q  <= 1'b0;
              lockErr_q <= 1'b0;
            end else begin
              cfgErr_q <= 1'b1;
            end
          end
          if (busIdle) begin
            gen_q      <= (CfgWr && wrValid) ? genCfg_t'(CfgData) : shadow_q;
            genReset_q <= 1'b1;
            holdCnt_q  <= '0;
          end
        end
        ST_HOLD: begin
          if (CfgWr) cfgErr_q <= 1'b1;
          holdCnt_q <= holdCnt_q + HOLD_W'(1);
          if (holdDone) begin
            genReset_q <= 1'b0;
            tmo_q      <= '0;
          end
        end
        ST_LOCK: begin
          if (CfgWr) cfgErr_q <= 1'b1;
          tmo_q <= tmo_q + TMO_W'(1);
          if (inRise) begin
            divCnt_q <= '0;
          end else if (tmoDone) begin
            divCnt_q  <= '0;
            lockErr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tick enables and busy flag decoded from the current state.
  always_comb begin
    RxTick  = inRun && inRise;
    TxTick  = inRun && inRise && (gen_q.sync || (divCnt_q == DIV_LAST));
    CfgBusy = !inRun;
  end

  assign GenReset    = genReset_q;
  assign GenMode     = gen_q.mode;
  assign GenSync     = gen_q.sync;
  assign GenBaudrate = gen_q.baud;
  assign CfgErr      = cfgErr_q;
  assign LockErr     = lockErr_q;

endmodule

// File: tb/tb_usart_clk_ctrl.sv
// Randomized scoreboard bench for usart_clk_ctrl: stimulus pushes expected
// ticks, a monitor pops them whenever the DUT raises TxTick/RxTick.
module tb_usart_clk_ctrl;

  localparam int HOLD = 4;
  localparam int OS   = 16;
  localparam int LT   = 300;

  logic       CPUClk  = 1'b0;
  logic       Reset_n = 1'b1;
  logic       CfgWr   = 1'b0;
  logic [5:0] CfgData = 6'd0;
  logic       TxBusy  = 1'b0;
  logic       RxBusy  = 1'b0;
  logic       InClk   = 1'b0;
  logic       GenReset, GenMode, GenSync;
  logic [3:0] GenBaudrate;
  logic       TxTick, RxTick, CfgBusy, CfgErr, LockErr;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    bit tx;
    bit rx;
  } tick_t;

  tick_t    expQ[$];
  tick_t    monExp;
  int       rxSeen = 0;
  int       txSeen = 0;
  int       riseCount = 0;
  bit       modelSync = 1'b0;
  bit [5:0] modelGen = 6'd0;

  usart_clk_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .OVERSAMPLE   (OS),
    .LOCK_TIMEOUT (LT),
    .TMO_W        (16)
  ) dut (
    .CPUClk      (CPUClk),
    .Reset_n     (Reset_n),
    .CfgWr       (CfgWr),
    .CfgData     (CfgData),
    .TxBusy      (TxBusy),
    .RxBusy      (RxBusy),
    .InClk       (InClk),
    .GenReset    (GenReset),
    .GenMode     (GenMode),
    .GenSync     (GenSync),
    .GenBaudrate (GenBaudrate),
    .TxTick      (TxTick),
    .RxTick      (RxTick),
    .CfgBusy     (CfgBusy),
    .CfgErr      (CfgErr),
    .LockErr     (LockErr)
  );

  always #5 CPUClk = ~CPUClk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every tick the DUT presents is matched against the oldest expectation.
  always @(negedge CPUClk) begin
    if (Reset_n && (RxTick || TxTick)) begin
      if (TxTick) txSeen++;
      if (RxTick) rxSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedTick", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("tickRx", int'(RxTick), int'(monExp.rx));
        checkOutput("tickTx", int'(TxTick), int'(monExp.tx));
      end
    end
  end

  // Drives InClk rising edges while in RUN and predicts each resulting tick.
  task automatic applyStimulus(input int rises);
    tick_t e;
    for (int i = 0; i < rises; i++) begin
      @(posedge CPUClk);
      #1 InClk = 1'b1;
      riseCount++;
      e.rx = 1'b1;
      e.tx = modelSync || ((riseCount % OS) == 0);
      expQ.push_back(e);
      repeat (3) @(posedge CPUClk);
      #1 InClk = 1'b0;
      repeat ($urandom_range(2, 4)) @(posedge CPUClk);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "GenReset"}, int'(GenReset), 1);
    checkOutput({tag, "GenMode"}, int'(GenMode), 0);
    checkOutput({tag, "GenSync"}, int'(GenSync), 0);
    checkOutput({tag, "GenBaud"}, int'(GenBaudrate), 0);
    checkOutput({tag, "TxTick"}, int'(TxTick), 0);
    checkOutput({tag, "RxTick"}, int'(RxTick), 0);
    checkOutput({tag, "CfgBusy"}, int'(CfgBusy), 1);
    checkOutput({tag, "CfgErr"}, int'(CfgErr), 0);
    checkOutput({tag, "LockErr"}, int'(LockErr), 0);
  endtask

  task automatic writeCfg(input bit [5:0] d);
    @(posedge CPUClk);
    #1 CfgWr = 1'b1;
    CfgData = d;
    @(posedge CPUClk);
    #1 CfgWr = 1'b0;
  endtask

  // Finds the generator reset pulse, checks its length and the applied settings.
  task automatic waitHold();
    int n;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CPUClk);
      if (GenReset) found = 1'b1;
    end
    checkOutput("holdSeen", int'(found), 1);
    if (found) begin
      checkOutput("genMode", int'(GenMode), int'(modelGen[5]));
      checkOutput("genSync", int'(GenSync), int'(modelGen[4]));
      checkOutput("genBaud", int'(GenBaudrate), int'(modelGen[3:0]));
      n = 1;
      for (int i = 0; i < 60 && GenReset; i++) begin
        @(negedge CPUClk);
        if (GenReset) n++;
      end
      checkOutput("holdLength", n, HOLD);
    end
  endtask

  // First synced rise in LOCK: CfgBusy must drop exactly on the following cycle.
  task automatic lockPulse();
    @(posedge CPUClk);
    #1 InClk = 1'b1;
    repeat (2) @(posedge CPUClk);
    @(negedge CPUClk);
    checkOutput("lockBusyBeforeRise", int'(CfgBusy), 1);
    @(posedge CPUClk);
    @(negedge CPUClk);
    checkOutput("lockBusyAfterRise", int'(CfgBusy), 0);
    InClk = 1'b0;
    riseCount = 0;
    modelSync = modelGen[4];
    repeat (3) @(posedge CPUClk);
  endtask

  function automatic bit [5:0] randCfg();
    bit [5:0] d;
    d[5]   = 1'($urandom_range(0, 1));
    d[4]   = 1'($urandom_range(0, 1));
    d[3:0] = 4'($urandom_range(0, 13));
    return d;
  endfunction

  initial begin
    int rx0, tx0, n;
    bit [5:0] d;

    // Asynchronous reset, checked before any clock edge.
    #3 Reset_n = 1'b0;
    #1 checkResetValues("rst_");
    repeat (3) @(posedge CPUClk);
    #1 Reset_n = 1'b1;
    modelGen = 6'd0;
    waitHold();
    lockPulse();

    // Async mode: 32 rises -> 32 RxTick, TxTick on rises 16 and 32.
    rx0 = rxSeen;
    tx0 = txSeen;
    applyStimulus(32);
    repeat (6) @(posedge CPUClk);
    checkOutput("asyncRxCount", rxSeen - rx0, 32);
    checkOutput("asyncTxCount", txSeen - tx0, 2);

    // Write deferred while the transmitter is busy.
    TxBusy = 1'b1;
    writeCfg(6'b01_0101);
    repeat (10) @(posedge CPUClk);
    @(negedge CPUClk);
    checkOutput("deferBaud", int'(GenBaudrate), 0);
    checkOutput("deferSync", int'(GenSync), 0);
    checkOutput("deferBusy", int'(CfgBusy), 1);
    checkOutput("deferGenReset", int'(GenReset), 0);
    @(posedge CPUClk);
    #1 TxBusy = 1'b0;
    modelGen = 6'b01_0101;
    waitHold();
    lockPulse();
    applyStimulus(8);

    // Invalid baudrate rejected, then cleared by the next accepted write.
    writeCfg(6'b00_1110);
    @(negedge CPUClk);
    checkOutput("badCfgErr", int'(CfgErr), 1);
    checkOutput("badCfgBusy", int'(CfgBusy), 0);
    checkOutput("badCfgBaud", int'(GenBaudrate), 5);
    applyStimulus(5);

    // Randomized reconfigurations with random busy windows.
    for (int k = 0; k < 3; k++) begin
      d = randCfg();
      RxBusy = 1'($urandom_range(0, 1));
      TxBusy = 1'($urandom_range(0, 1));
      writeCfg(d);
      @(negedge CPUClk);
      checkOutput("validClearsCfgErr", int'(CfgErr), 0);
      repeat ($urandom_range(1, 8)) @(posedge CPUClk);
      #1 RxBusy = 1'b0;
      TxBusy = 1'b0;
      modelGen = d;
      waitHold();
      lockPulse();
      applyStimulus($urandom_range(5, 40));
    end

    // Lock timeout with InClk held low.
    d = randCfg();
    writeCfg(d);
    modelGen = d;
    waitHold();
    n = 0;
    for (int i = 0; i < LT + 50; i++) begin
      @(posedge CPUClk);
      n++;
      @(negedge CPUClk);
      if (!CfgBusy) break;
    end
    checkOutput("lockTimeoutCycles", n, LT + 1);
    checkOutput("lockErrSet", int'(LockErr), 1);
    checkOutput("timeoutBusy", int'(CfgBusy), 0);

    // Accepted write clears LockErr; writes during LOCK are rejected.
    d = randCfg();
    writeCfg(d);
    @(negedge CPUClk);
    checkOutput("lockErrCleared", int'(LockErr), 0);
    modelGen = d;
    waitHold();
    writeCfg(randCfg());
    @(negedge CPUClk);
    checkOutput("lockWriteErr", int'(CfgErr), 1);
    checkOutput("lockWriteBusy", int'(CfgBusy), 1);

    // Reset while in LOCK: outputs return to reset values without a clock edge.
    @(posedge CPUClk);
    #2 Reset_n = 1'b0;
    #1 checkResetValues("midRst_");
    repeat (2) @(posedge CPUClk);
    #1 Reset_n = 1'b1;
    modelGen = 6'd0;
    waitHold();
    lockPulse();
    applyStimulus(4);

    repeat (10) @(posedge CPUClk);
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
